// File: rtl/lcd_line_pingpong.sv
// Two-bank line store between the pixel renderer and the LCD serialiser.
// The producer fills one bank while the consumer streams the other.
module lcd_line_pingpong #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_LEN   = 480,
    parameter int ADDR_BITS  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  wr_line_done,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic [1:0]            lines_ready
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(LINE_LEN - 1);

    logic [DATA_WIDTH-1:0] mem [2][LINE_LEN];

    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]           full_q, full_d;
    logic                 wr_line_done_q, wr_line_done_d;

    logic wr_fire, rd_fire, wr_at_last, rd_at_last;

    assign wr_ready     = ~full_q[wr_bank_q];
    assign rd_valid     = full_q[rd_bank_q];
    assign rd_last      = rd_valid & (rd_addr_q == LAST_ADDR);
    assign lines_ready  = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign rd_data      = mem[rd_bank_q][rd_addr_q];
    assign wr_line_done = wr_line_done_q;

    // flush wins over both handshakes, so it also gates the RAM write
    assign wr_fire    = wr_valid & wr_ready & ~flush;
    assign rd_fire    = rd_valid & rd_ready & ~flush;
    assign wr_at_last = (wr_addr_q == LAST_ADDR);
    assign rd_at_last = (rd_addr_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank_q][wr_addr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_bank_d      = wr_bank_q;
        rd_bank_d      = rd_bank_q;
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        full_d         = full_q;
        wr_line_done_d = 1'b0;

        if (flush) begin
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_addr_d = '0;
            rd_addr_d = '0;
            full_d    = 2'b00;
        end else begin
            if (wr_fire) begin
                if (wr_at_last) begin
                    wr_addr_d         = '0;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_line_done_d    = 1'b1;
                end else begin
                    wr_addr_d = wr_addr_q + ADDR_BITS'(1);
                end
            end
            // A completing write and read always touch different banks
            if (rd_fire) begin
                if (rd_at_last) begin
                    rd_addr_d         = '0;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            full_q         <= 2'b00;
            wr_line_done_q <= 1'b0;
        end else begin
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            full_q         <= full_d;
            wr_line_done_q <= wr_line_done_d;
        end
    end

endmodule

// File: tb/tb_lcd_line_pingpong.sv
// Directed bench for lcd_line_pingpong with a line-level queue model.
module tb_lcd_line_pingpong;

    localparam int LINE = 480;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_ready = 1'b0;
    logic       wr_ready, wr_line_done, rd_valid, rd_last;
    logic [7:0] rd_data;
    logic [1:0] lines_ready;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    int         wcnt = 0;
    int         rcnt = 0;
    int         mlines = 0;
    logic       exp_done = 1'b0;

    lcd_line_pingpong #(.DATA_WIDTH(8), .LINE_LEN(LINE), .ADDR_BITS(9)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .wr_line_done(wr_line_done), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .rd_ready(rd_ready), .lines_ready(lines_ready)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        exp_q.delete();
        wcnt = 0;
        rcnt = 0;
        mlines = 0;
        exp_done = 1'b0;
    endtask

    // Advance one clock and update the line-level model from the driven inputs.
    task automatic tick();
        logic wacc, racc;
        @(posedge clk);
        wacc = wr_valid && (mlines < 2);
        racc = rd_ready && (mlines > 0);
        exp_done = 1'b0;
        if (!rst_n || flush) begin
            model_clear();
        end else begin
            if (racc) begin
                void'(exp_q.pop_front());
                rcnt++;
                if (rcnt == LINE) begin
                    rcnt = 0;
                    mlines--;
                end
            end
            if (wacc) begin
                exp_q.push_back(wr_data);
                wcnt++;
                if (wcnt == LINE) begin
                    wcnt = 0;
                    mlines++;
                    exp_done = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        #12;
        tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_wr_ready: got %b want 1", wr_ready); end
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_valid: got %b want 0", rd_valid); end
        tests_run++; if (rd_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_last: got %b want 0", rd_last); end
        tests_run++; if (wr_line_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_line_done: got %b want 0", wr_line_done); end
        tests_run++; if (lines_ready !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_lines_ready: got %0d want 0", lines_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_line();
        int done_cnt = 0;
        rd_ready = 1'b0;
        for (int i = 0; i < LINE; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_wr_ready[%0d]: got %b want 1", i, wr_ready); end
            tick();
            tests_run++; if (wr_line_done !== (i == LINE - 1)) begin tests_failed++; $display("[TB] FAIL fill_line_done[%0d]: got %b want %b", i, wr_line_done, (i == LINE - 1)); end
            if (wr_line_done) done_cnt++;
        end
        wr_valid = 1'b0;
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL fill_done_pulses: got %0d want 1", done_cnt); end
        tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_rd_valid: got %b want 1", rd_valid); end
        tests_run++; if (lines_ready !== 2'd1) begin tests_failed++; $display("[TB] FAIL fill_lines_ready: got %0d want 1", lines_ready); end
        tests_run++; if (rd_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL fill_rd_data: got %h want 00", rd_data); end
        tests_run++; if (rd_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_rd_last: got %b want 0", rd_last); end
        tick();
        tests_run++; if (wr_line_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_done_clear: got %b want 0", wr_line_done); end
    endtask

    task automatic test_both_full();
        rd_ready = 1'b0;
        for (int i = 0; i < LINE; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(LINE + i);
            tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_wr_ready[%0d]: got %b want 1", i, wr_ready); end
            tick();
        end
        wr_data = 8'hA5;
        tests_run++; if (lines_ready !== 2'd2) begin tests_failed++; $display("[TB] FAIL full_lines_ready: got %0d want 2", lines_ready); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_stall[%0d]: got %b want 0", i, wr_ready); end
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < LINE; i++) begin
            tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_rd_valid[%0d]: got %b want 1", i, rd_valid); end
            tests_run++; if (rd_data !== 8'(i)) begin tests_failed++; $display("[TB] FAIL full_rd_data[%0d]: got %h want %h", i, rd_data, 8'(i)); end
            tests_run++; if (rd_last !== (i == LINE - 1)) begin tests_failed++; $display("[TB] FAIL full_rd_last[%0d]: got %b want %b", i, rd_last, (i == LINE - 1)); end
            tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_wr_held[%0d]: got %b want 0", i, wr_ready); end
            tick();
        end
        rd_ready = 1'b0;
        tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_wr_reopen: got %b want 1", wr_ready); end
        tests_run++; if (lines_ready !== 2'd1) begin tests_failed++; $display("[TB] FAIL full_lines_after: got %0d want 1", lines_ready); end
        tests_run++; if (rd_data !== 8'hE0) begin tests_failed++; $display("[TB] FAIL full_bank1_first: got %h want e0", rd_data); end
        tick();
        for (int i = 1; i < LINE; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i + 7);
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 2 * LINE; i++) begin
            tests_run++; if (rd_data !== exp_q[0]) begin tests_failed++; $display("[TB] FAIL full_drain[%0d]: got %h want %h", i, rd_data, exp_q[0]); end
            if (i == LINE) begin
                tests_run++; if (rd_data !== 8'hA5) begin tests_failed++; $display("[TB] FAIL full_held_word: got %h want a5", rd_data); end
            end
            tick();
        end
        rd_ready = 1'b0;
        tests_run++; if (lines_ready !== 2'd0) begin tests_failed++; $display("[TB] FAIL full_drained: got %0d want 0", lines_ready); end
    endtask

    task automatic test_streaming();
        rd_ready = 1'b0;
        for (int i = 0; i < LINE; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i * 3);
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3 * LINE; i++) begin
            wr_data = 8'(i * 5 + 1);
            tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL stream_wr_ready[%0d]: got %b want 1", i, wr_ready); end
            tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stream_rd_valid[%0d]: got %b want 1", i, rd_valid); end
            tests_run++; if (rd_data !== exp_q[0]) begin tests_failed++; $display("[TB] FAIL stream_rd_data[%0d]: got %h want %h", i, rd_data, exp_q[0]); end
            tests_run++; if (lines_ready < 2'd1 || lines_ready > 2'd2) begin tests_failed++; $display("[TB] FAIL stream_lines[%0d]: got %0d want 1..2", i, lines_ready); end
            tick();
        end
        wr_valid = 1'b0;
        for (int i = 0; i < LINE; i++) begin
            tests_run++; if (rd_data !== exp_q[0]) begin tests_failed++; $display("[TB] FAIL stream_tail[%0d]: got %h want %h", i, rd_data, exp_q[0]); end
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_random();
        int  wrote = 0;
        int  last_cnt = 0;
        bit  done = 1'b0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            wr_valid = (wrote < 20 * LINE) && ($urandom_range(0, 1) == 1);
            wr_data  = 8'($urandom_range(0, 255));
            rd_ready = ($urandom_range(0, 1) == 1);
            tests_run++; if (wr_ready !== (mlines < 2)) begin tests_failed++; $display("[TB] FAIL rand_wr_ready[%0d]: got %b want %b", cyc, wr_ready, (mlines < 2)); end
            tests_run++; if (rd_valid !== (mlines > 0)) begin tests_failed++; $display("[TB] FAIL rand_rd_valid[%0d]: got %b want %b", cyc, rd_valid, (mlines > 0)); end
            if (mlines > 0 && rd_ready) begin
                tests_run++; if (rd_data !== exp_q[0]) begin tests_failed++; $display("[TB] FAIL rand_rd_data[%0d]: got %h want %h", cyc, rd_data, exp_q[0]); end
                tests_run++; if (rd_last !== (rcnt == LINE - 1)) begin tests_failed++; $display("[TB] FAIL rand_rd_last[%0d]: got %b want %b", cyc, rd_last, (rcnt == LINE - 1)); end
                if (rd_last) last_cnt++;
            end
            if (wr_valid && mlines < 2) wrote++;
            tick();
            if (wrote == 20 * LINE && mlines == 0) begin
                done = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        tests_run++; if (!done) begin tests_failed++; $display("[TB] FAIL rand_timeout: got wrote=%0d lines=%0d want 9600/0", wrote, mlines); end
        tests_run++; if (last_cnt != 20) begin tests_failed++; $display("[TB] FAIL rand_last_count: got %0d want 20", last_cnt); end
    endtask

    task automatic test_flush();
        rd_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i + 40);
            tick();
        end
        wr_data = 8'h5A;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_wr_ready: got %b want 1", wr_ready); end
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_rd_valid: got %b want 0", rd_valid); end
        tests_run++; if (lines_ready !== 2'd0) begin tests_failed++; $display("[TB] FAIL flush_lines_ready: got %0d want 0", lines_ready); end
        for (int i = 0; i < LINE; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(255 - i);
            tick();
            tests_run++; if (wr_line_done !== (i == LINE - 1)) begin tests_failed++; $display("[TB] FAIL flush_line_done[%0d]: got %b want %b", i, wr_line_done, (i == LINE - 1)); end
        end
        wr_valid = 1'b0;
        tests_run++; if (lines_ready !== 2'd1) begin tests_failed++; $display("[TB] FAIL flush_refill_lines: got %0d want 1", lines_ready); end
        rd_ready = 1'b1;
        for (int i = 0; i < LINE; i++) begin
            tests_run++; if (rd_data !== 8'(255 - i)) begin tests_failed++; $display("[TB] FAIL flush_rd_data[%0d]: got %h want %h", i, rd_data, 8'(255 - i)); end
            tests_run++; if (rd_last !== (i == LINE - 1)) begin tests_failed++; $display("[TB] FAIL flush_rd_last[%0d]: got %b want %b", i, rd_last, (i == LINE - 1)); end
            tick();
        end
        rd_ready = 1'b0;
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_drained: got %b want 0", rd_valid); end
    endtask

    task automatic test_async_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 2 * LINE; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i) ^ 8'h3C;
            tick();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL arst_wr_ready: got %b want 1", wr_ready); end
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_rd_valid: got %b want 0", rd_valid); end
        tests_run++; if (rd_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_rd_last: got %b want 0", rd_last); end
        tests_run++; if (lines_ready !== 2'd0) begin tests_failed++; $display("[TB] FAIL arst_lines_ready: got %0d want 0", lines_ready); end
        tests_run++; if (wr_line_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_line_done: got %b want 0", wr_line_done); end
        rd_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < LINE; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i + 100);
            tick();
        end
        wr_valid = 1'b0;
        tests_run++; if (lines_ready !== 2'd1) begin tests_failed++; $display("[TB] FAIL arst_refill_lines: got %0d want 1", lines_ready); end
        rd_ready = 1'b1;
        for (int i = 0; i < LINE; i++) begin
            tests_run++; if (rd_data !== 8'(i + 100)) begin tests_failed++; $display("[TB] FAIL arst_rd_data[%0d]: got %h want %h", i, rd_data, 8'(i + 100)); end
            tick();
        end
        rd_ready = 1'b0;
        tests_run++; if (lines_ready !== 2'd0) begin tests_failed++; $display("[TB] FAIL arst_drained: got %0d want 0", lines_ready); end
    endtask

    initial begin
        test_reset();
        test_fill_line();
        test_both_full();
        test_streaming();
        test_random();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
